ahb_mst_stage: RTL

Per-master input stage of the AHB matrix, directly upstream of the per-slave arbiters. It accepts AHB-Lite address phases from one master and decodes the target slave. It holds the address phase while raising the request to that slave's arbiter, issues the phase on grant, and returns the selected slave's data-phase response to the master. Unmapped addresses get a two-cycle ERROR response without any arbitration.

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahb_mst_dec.sv | 27 ++
 rtl/ahb_mst_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings for the matrix master stage.
// HTRANS/HRESP codes and the master-stage FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GNT = 3'd1,
    ST_DATA     = 3'd2,
    ST_ERR1     = 3'd3,
    ST_ERR2     = 3'd4
  } mst_state_e;

endpackage

// File: rtl/ahb_mst_dec.sv
// ahb_mst_dec: base/mask address decoder for one master port.
// Lowest-index matching slave wins; no match drops hit_o.
module ahb_mst_dec #(
  parameter int SLAVES     = 4,
  parameter int AW         = 32,
  parameter int SLAVES_BIT = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic [AW-1:0]         addr_i,
  input  logic [AW-1:0]         base_i [SLAVES],
  input  logic [AW-1:0]         mask_i [SLAVES],
  output logic                  hit_o,
  output logic [SLAVES_BIT-1:0] sel_o
);

  // scan high to low so the lowest matching index is the last one written
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if ((addr_i & mask_i[s]) == base_i[s]) begin
        hit_o = 1'b1;
        sel_o = SLAVES_BIT'(s);
      end
    end
  end

endmodule

// File: rtl/ahb_mst_stage.sv
// ahb_mst_stage: per-master input stage of the AHB matrix.
// Holds each address phase, requests its slave arbiter, relays the response.
module ahb_mst_stage
  import ahb_pkg::*;
#(
  parameter  int SLAVES     = 4,
  parameter  int AW         = 32,
  parameter  int DW         = 32,
  localparam int SLAVES_BIT = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [AW-1:0]     SLAVE_BASE [SLAVES],
  input  logic [AW-1:0]     SLAVE_MASK [SLAVES],
  input  logic [AW-1:0]     M_HADDR,
  input  logic [1:0]        M_HTRANS,
  input  logic              M_HWRITE,
  input  logic [2:0]        M_HSIZE,
  input  logic [2:0]        M_HBURST,
  input  logic [3:0]        M_HPROT,
  input  logic              M_HMASTLOCK,
  input  logic [DW-1:0]     M_HWDATA,
  input  logic              M_HREADY,
  output logic              M_HREADYOUT,
  output logic              M_HRESP,
  output logic [DW-1:0]     M_HRDATA,
  output logic [SLAVES-1:0] ARB_REQ,
  input  logic [SLAVES-1:0] ARB_GRANT,
  output logic [SLAVES-1:0] ARB_GRANT_ACK,
  output logic              ARB_PRIORITY_LOCK,
  output logic [AW-1:0]     S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [2:0]        S_HBURST,
  output logic [3:0]        S_HPROT,
  output logic              S_HMASTLOCK,
  output logic [DW-1:0]     S_HWDATA,
  input  logic [SLAVES-1:0] S_HREADY,
  input  logic [SLAVES-1:0] S_HREADYOUT,
  input  logic [SLAVES-1:0] S_HRESP,
  input  logic [DW-1:0]     S_HRDATA [SLAVES]
);

  mst_state_e            state_q;
  logic [AW-1:0]         addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [2:0]            burst_q;
  logic [3:0]            prot_q;
  logic                  lock_q;
  logic [SLAVES_BIT-1:0] sel_q;

  logic                  dec_hit;
  logic [SLAVES_BIT-1:0] dec_sel;
  logic                  capture;
  logic                  issue;
  logic                  s_done;
  logic                  unused_htrans0;

  // SEQ and NONSEQ are treated alike: every beat re-arbitrates
  assign unused_htrans0 = M_HTRANS[0];

  ahb_mst_dec #(
    .SLAVES     (SLAVES),
    .AW         (AW),
    .SLAVES_BIT (SLAVES_BIT)
  ) u_dec (
    .addr_i (M_HADDR),
    .base_i (SLAVE_BASE),
    .mask_i (SLAVE_MASK),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  assign capture = M_HREADY & M_HREADYOUT & M_HTRANS[1];
  assign issue   = (state_q == ST_WAIT_GNT)
                 & ARB_GRANT[sel_q] & S_HREADY[sel_q];
  assign s_done  = S_HREADYOUT[sel_q];

  // held address phase drives the shared slave-side bus
  assign S_HADDR     = addr_q;
  assign S_HWRITE    = write_q;
  assign S_HSIZE     = size_q;
  assign S_HBURST    = burst_q;
  assign S_HPROT     = prot_q;
  assign S_HMASTLOCK = lock_q;
  assign S_HWDATA    = M_HWDATA;

  // state register and holding register for the accepted address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      lock_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      if (capture) begin
        addr_q  <= M_HADDR;
        write_q <= M_HWRITE;
        size_q  <= M_HSIZE;
        burst_q <= M_HBURST;
        prot_q  <= M_HPROT;
        lock_q  <= M_HMASTLOCK;
        sel_q   <= dec_sel;
      end
      unique case (state_q)
        ST_IDLE, ST_ERR2: begin
          if (capture) begin
            state_q <= dec_hit ? ST_WAIT_GNT : ST_ERR1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_GNT: begin
          if (issue) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_done) begin
            if (capture) begin
              state_q <= dec_hit ? ST_WAIT_GNT : ST_ERR1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_ERR1: state_q <= ST_ERR2;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // master response, arbiter handshake and slave HTRANS decoded from state
  always_comb begin
    M_HREADYOUT       = 1'b1;
    M_HRESP           = HRESP_OKAY;
    M_HRDATA          = '0;
    ARB_REQ           = '0;
    ARB_GRANT_ACK     = '0;
    ARB_PRIORITY_LOCK = 1'b0;
    S_HTRANS          = HTRANS_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        M_HREADYOUT = 1'b1;
      end
      ST_WAIT_GNT: begin
        M_HREADYOUT       = 1'b0;
        ARB_REQ[sel_q]    = 1'b1;
        ARB_PRIORITY_LOCK = lock_q;
        if (issue) begin
          ARB_GRANT_ACK[sel_q] = 1'b1;
          S_HTRANS             = HTRANS_NONSEQ;
        end
      end
      ST_DATA: begin
        M_HREADYOUT       = S_HREADYOUT[sel_q];
        M_HRESP           = S_HRESP[sel_q];
        M_HRDATA          = S_HRDATA[sel_q];
        ARB_PRIORITY_LOCK = lock_q;
      end
      ST_ERR1: begin
        M_HREADYOUT = 1'b0;
        M_HRESP     = HRESP_ERROR;
      end
      ST_ERR2: begin
        M_HREADYOUT = 1'b1;
        M_HRESP     = HRESP_ERROR;
      end
      default: begin
        M_HREADYOUT = 1'b1;
      end
    endcase
  end

endmodule
